// File: rtl/tank_pkg.sv
// Shared tank/bullet definitions: fixed-point formats, screen bounds,
// sign-magnitude trig type and the velocity scaling helper used by both
// the tank controllers and the bullet manager.
package tank_pkg;

  localparam int unsigned FRAC_BITS = 3;
  localparam int unsigned SCREEN_W  = 640;
  localparam int unsigned SCREEN_H  = 480;

  // Position: unsigned, 3 fractional bits (pixel = pos[12:3]).
  typedef logic [12:0]        pos_t;
  // Velocity: two's complement in 1/8-pixel units per frame.
  typedef logic signed [12:0] vel_t;

  // Sign-magnitude trig value, mag 127 = 1.0.
  typedef struct packed {
    logic       sign;
    logic [6:0] mag;
  } sm8_t;

  // What a bullet slot does in the current frame, highest priority first.
  typedef enum logic [2:0] {
    ACT_IDLE,
    ACT_SPAWN,
    ACT_HIT,
    ACT_EXPIRE,
    ACT_OFFSCREEN,
    ACT_MOVE
  } slot_act_e;

  // (speed * mag) >> 7, sign applied after the magnitude is formed so that
  // positive and negative directions have identical speed.
  function automatic vel_t sm_scale(input sm8_t s, input int unsigned speed);
    logic [31:0] prod;
    logic [12:0] mag;
    prod = speed * {25'd0, s.mag};
    mag  = 13'(prod >> 7);
    return s.sign ? vel_t'(-mag) : vel_t'(mag);
  endfunction

endpackage

// File: rtl/bullet_slot.sv
// One bullet slot: holds position, velocity, age and occupancy; each frame
// applies hit / expiry / off-screen / bounce / move in priority order.
// Ports:
//   frame_clk, Reset       frame clock, async active-high reset
//   clear_i                synchronous clear (round over)
//   spawn_i, spawn_*_i     load strobe with initial position/velocity
//   enemy_*_i              opponent centre and half-extent (pixels)
//   wall_x_hit_i/_y_hit_i  wall contact at current position
//   active_o, px_o, py_o   occupancy and pixel position (0 when inactive)
//   hit_o                  combinational: this slot strikes the opponent now
module bullet_slot
  import tank_pkg::*;
#(
  parameter int unsigned LIFETIME   = 300,
  parameter int unsigned ARM_FRAMES = 4
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       clear_i,
  input  logic       spawn_i,
  input  pos_t       spawn_x_i,
  input  pos_t       spawn_y_i,
  input  vel_t       spawn_vx_i,
  input  vel_t       spawn_vy_i,
  input  logic [9:0] enemy_x_i,
  input  logic [9:0] enemy_y_i,
  input  logic [9:0] enemy_size_i,
  input  logic       wall_x_hit_i,
  input  logic       wall_y_hit_i,
  output logic       active_o,
  output logic [9:0] px_o,
  output logic [9:0] py_o,
  output logic       hit_o
);

  localparam logic [9:0] AGE_ARM  = 10'(ARM_FRAMES);
  localparam logic [9:0] AGE_LAST = 10'(LIFETIME - 1);
  localparam logic [9:0] PX_MAX   = 10'(SCREEN_W - 1);
  localparam logic [9:0] PY_MAX   = 10'(SCREEN_H - 1);

  logic       active_q, active_d;
  pos_t       x_q, x_d, y_q, y_d;
  vel_t       vx_q, vx_d, vy_q, vy_d;
  logic [9:0] age_q, age_d;

  logic [9:0] px, py, dx, dy;
  vel_t       vx_b, vy_b;
  slot_act_e  act;

  assign px = x_q[12:FRAC_BITS];
  assign py = y_q[12:FRAC_BITS];

  // Action selection. A slot never spawns while occupied, so spawn simply
  // pre-empts everything else.
  always_comb begin
    dx  = (px >= enemy_x_i) ? px - enemy_x_i : enemy_x_i - px;
    dy  = (py >= enemy_y_i) ? py - enemy_y_i : enemy_y_i - py;
    act = ACT_IDLE;
    if (spawn_i) begin
      act = ACT_SPAWN;
    end else if (active_q) begin
      if (age_q >= AGE_ARM && dx <= enemy_size_i && dy <= enemy_size_i)
        act = ACT_HIT;
      else if (age_q == AGE_LAST)
        act = ACT_EXPIRE;
      else if (px > PX_MAX || py > PY_MAX)
        act = ACT_OFFSCREEN;
      else
        act = ACT_MOVE;
    end
  end

  // Bounce is folded into the step: reflected velocity is both stored and
  // used for this frame's displacement.
  always_comb begin
    vx_b     = wall_x_hit_i ? vel_t'(-vx_q) : vx_q;
    vy_b     = wall_y_hit_i ? vel_t'(-vy_q) : vy_q;
    active_d = active_q;
    x_d      = x_q;
    y_d      = y_q;
    vx_d     = vx_q;
    vy_d     = vy_q;
    age_d    = age_q;
    unique case (act)
      ACT_SPAWN: begin
        active_d = 1'b1;
        x_d      = spawn_x_i;
        y_d      = spawn_y_i;
        vx_d     = spawn_vx_i;
        vy_d     = spawn_vy_i;
        age_d    = '0;
      end
      ACT_HIT, ACT_EXPIRE, ACT_OFFSCREEN: begin
        active_d = 1'b0;
        x_d      = '0;
        y_d      = '0;
        vx_d     = '0;
        vy_d     = '0;
        age_d    = '0;
      end
      ACT_MOVE: begin
        vx_d  = vx_b;
        vy_d  = vy_b;
        x_d   = x_q + pos_t'(vx_b);
        y_d   = y_q + pos_t'(vy_b);
        age_d = age_q + 10'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      active_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      vx_q     <= '0;
      vy_q     <= '0;
      age_q    <= '0;
    end else if (clear_i) begin
      active_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      vx_q     <= '0;
      vy_q     <= '0;
      age_q    <= '0;
    end else begin
      active_q <= active_d;
      x_q      <= x_d;
      y_q      <= y_d;
      vx_q     <= vx_d;
      vy_q     <= vy_d;
      age_q    <= age_d;
    end
  end

  assign active_o = active_q;
  assign px_o     = px;
  assign py_o     = py;
  assign hit_o    = (act == ACT_HIT);

endmodule

// File: rtl/bullet_manager.sv
// Per-player bullet manager: fire edge detect, spawn cooldown, lowest-free
// slot selection, and aggregation of slot hits into a single pulse.
// Ports:
//   frame_clk, Reset        frame clock, async active-high reset
//   game_end                nonzero: synchronous clear of everything
//   fire                    fire request level
//   tank_x/tank_y, sin/cos  firing tank pose (pixels, sign-magnitude trig)
//   enemy_x/_y/_size        opponent centre and half-extent
//   wall_x_hit/wall_y_hit   per-slot wall contact
//   bullet_active/_x/_y     per-slot occupancy and pixel position
//   hit, fire_ack           one-frame pulses
module bullet_manager
  import tank_pkg::*;
#(
  parameter int unsigned NUM_BULLETS  = 4,
  parameter int unsigned BULLET_SPEED = 24,
  parameter int unsigned LIFETIME     = 300,
  parameter int unsigned COOLDOWN     = 15,
  parameter int unsigned ARM_FRAMES   = 4
) (
  input  logic                      frame_clk,
  input  logic                      Reset,
  input  logic [1:0]                game_end,
  input  logic                      fire,
  input  logic [9:0]                tank_x,
  input  logic [9:0]                tank_y,
  input  logic [7:0]                sin,
  input  logic [7:0]                cos,
  input  logic [9:0]                enemy_x,
  input  logic [9:0]                enemy_y,
  input  logic [9:0]                enemy_size,
  input  logic [NUM_BULLETS-1:0]    wall_x_hit,
  input  logic [NUM_BULLETS-1:0]    wall_y_hit,
  output logic [NUM_BULLETS-1:0]    bullet_active,
  output logic [NUM_BULLETS*10-1:0] bullet_x,
  output logic [NUM_BULLETS*10-1:0] bullet_y,
  output logic                      hit,
  output logic                      fire_ack
);

  localparam logic [15:0] CD_LOAD = 16'(COOLDOWN);

  logic                   fire_q;
  logic [15:0]            cd_q, cd_d;
  logic                   hit_q, ack_q;
  logic                   clear;
  logic                   fire_edge, do_spawn, found;
  logic [NUM_BULLETS-1:0] free_oh, spawn_vec, slot_hit;
  vel_t                   vx_sp, vy_sp;
  pos_t                   spawn_x, spawn_y;

  assign clear = |game_end;

  // Screen Y grows downward, so positive sin means negative vy.
  always_comb begin
    vx_sp   = sm_scale(sm8_t'(cos), BULLET_SPEED);
    vy_sp   = vel_t'(-sm_scale(sm8_t'(sin), BULLET_SPEED));
    spawn_x = {tank_x, 3'b000} + pos_t'(vx_sp <<< 2);
    spawn_y = {tank_y, 3'b000} + pos_t'(vy_sp <<< 2);
  end

  // Lowest-index slot that is free at the start of this frame.
  always_comb begin
    free_oh = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NUM_BULLETS; i++) begin
      if (!found && !bullet_active[i]) begin
        free_oh[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    fire_edge = fire & ~fire_q;
    do_spawn  = fire_edge && (cd_q == '0) && found;
    spawn_vec = do_spawn ? free_oh : '0;
    if (do_spawn)
      cd_d = CD_LOAD;
    else if (cd_q != '0)
      cd_d = cd_q - 16'd1;
    else
      cd_d = cd_q;
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      fire_q <= 1'b0;
      cd_q   <= '0;
      hit_q  <= 1'b0;
      ack_q  <= 1'b0;
    end else if (clear) begin
      fire_q <= 1'b0;
      cd_q   <= '0;
      hit_q  <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      fire_q <= fire;
      cd_q   <= cd_d;
      hit_q  <= |slot_hit;
      ack_q  <= do_spawn;
    end
  end

  for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_slot
    bullet_slot #(
      .LIFETIME   (LIFETIME),
      .ARM_FRAMES (ARM_FRAMES)
    ) u_slot (
      .frame_clk    (frame_clk),
      .Reset        (Reset),
      .clear_i      (clear),
      .spawn_i      (spawn_vec[g]),
      .spawn_x_i    (spawn_x),
      .spawn_y_i    (spawn_y),
      .spawn_vx_i   (vx_sp),
      .spawn_vy_i   (vy_sp),
      .enemy_x_i    (enemy_x),
      .enemy_y_i    (enemy_y),
      .enemy_size_i (enemy_size),
      .wall_x_hit_i (wall_x_hit[g]),
      .wall_y_hit_i (wall_y_hit[g]),
      .active_o     (bullet_active[g]),
      .px_o         (bullet_x[10*g +: 10]),
      .py_o         (bullet_y[10*g +: 10]),
      .hit_o        (slot_hit[g])
    );
  end

  assign hit      = hit_q;
  assign fire_ack = ack_q;

endmodule
